// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER fetch stage.
package otter_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory, redirect and decode signals of the fetch stage.
interface instr_fetch_if;
  import otter_fetch_pkg::*;

  // valid/ready: a transfer happens on a rising edge where both sides are high
  // (IMEM_REQ && IMEM_READY for memory, IR_VALID && IR_READY for decode);
  // the producer may not drop valid or change payload without a transfer.
  logic            IMEM_READY;
  logic            IMEM_REQ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic [XLEN-1:0] IMEM_RDATA;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_ADDR;
  logic [XLEN-1:0] IR;
  logic [XLEN-1:0] IR_PC;
  logic            IR_VALID;
  logic            IR_READY;

  modport master (
    input  IMEM_READY, IMEM_RDATA, REDIRECT, REDIRECT_ADDR, IR_READY,
    output IMEM_REQ, IMEM_ADDR, IR, IR_PC, IR_VALID
  );

  modport slave (
    output IMEM_READY, IMEM_RDATA, REDIRECT, REDIRECT_ADDR, IR_READY,
    input  IMEM_REQ, IMEM_ADDR, IR, IR_PC, IR_VALID
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, pc} entries; flush beats push and pop.
module fetch_fifo
  import otter_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !do_pop)      count_q <= count_q + CW'(1);
      else if (!push_i && do_pop) count_q <= count_q - CW'(1);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// OTTER fetch stage: PC, credit-limited issue to a 1-cycle imem, buffered hand-off to decode.
module instr_fetch
  import otter_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input logic           CLK,
  input logic           RST,
  instr_fetch_if.master bus
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            ir_valid;
  logic            pop;
  logic            imem_req;
  logic            accept;
  logic [CW1-1:0]  credit;

  // Reserve a slot for every word already in flight so a push never meets a full FIFO.
  assign ir_valid = !RST && (fifo_count != '0);
  assign pop      = ir_valid && bus.IR_READY;
  assign credit   = {1'b0, fifo_count} + CW1'(inflight_q) - CW1'(pop);
  assign imem_req = !RST && !bus.REDIRECT && (credit < CW1'(DEPTH));
  assign accept   = imem_req && bus.IMEM_READY;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = 1'b0;
    if (bus.REDIRECT) begin
      pc_d = {bus.REDIRECT_ADDR[XLEN-1:2], 2'b00};
    end else if (accept) begin
      pc_d       = pc_q + XLEN'(WORD_BYTES);
      resp_pc_d  = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && !bus.REDIRECT && inflight_q) begin
      assert (!fifo_full);
    end
  end

  assign push_entry = '{instr: bus.IMEM_RDATA, pc: resp_pc_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (bus.REDIRECT),
    .push_i  (inflight_q),
    .entry_i (push_entry),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .full_o  (fifo_full)
  );

  assign bus.IMEM_REQ  = imem_req;
  assign bus.IMEM_ADDR = pc_q;
  assign bus.IR        = fifo_head.instr;
  assign bus.IR_PC     = fifo_head.pc;
  assign bus.IR_VALID  = ir_valid;

endmodule
